// File: rtl/conv3_controller_pkg.sv
// Shared CNN layer-controller definitions: default feature-map geometry and
// the layer sequencing state type reused by the other layer controllers.
package conv3_controller_pkg;

  localparam int CNN_SIZE = 14;
  localparam int CNN_K    = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DONE
  } layer_state_e;

endpackage

// File: rtl/conv3_controller_window_counter.sv
// window_counter: pixel row/col tracking for one frame and registered
// window-result indices for the convolution output.
module window_counter
  import conv3_controller_pkg::*;
#(
  parameter int SIZE = CNN_SIZE,
  parameter int K    = CNN_K
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       acc,
  output logic       at_last,
  output logic       out_valid,
  output logic [3:0] out_row,
  output logic [3:0] out_col
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
  localparam logic [CW-1:0] WIN0 = CW'(K - 1);

  logic [CW-1:0] row_q, row_d, col_q, col_d;
  logic          out_valid_q, out_valid_d;
  logic [3:0]    out_row_q, out_row_d, out_col_q, out_col_d;
  logic          win_hit;

  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    out_valid_d = 1'b0;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    win_hit     = (row_q >= WIN0) && (col_q >= WIN0);
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (acc) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      // Window anchored at the bottom-right pixel just accepted
      if (win_hit) begin
        out_valid_d = 1'b1;
        out_row_d   = 4'(row_q - WIN0);
        out_col_d   = 4'(col_q - WIN0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  assign at_last   = (row_q == LAST) && (col_q == LAST);
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;

endmodule

// File: rtl/conv3_controller.sv
// conv3_controller: sequences weight load and pixel streaming for the conv3
// layer. Optional stall counter output enabled by CONV3_CTRL_PERF_EN.
module conv3_controller
  import conv3_controller_pkg::*;
#(
  parameter int SIZE         = CNN_SIZE,
  parameter int K            = CNN_K,
  parameter int WLOAD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        reload,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wb_read,
  output logic        conv_en,
  output logic        out_valid,
  output logic [3:0]  out_row,
  output logic [3:0]  out_col,
  output logic        busy,
  output logic        done
`ifdef CONV3_CTRL_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int LW = (WLOAD_CYCLES > 1) ? $clog2(WLOAD_CYCLES) : 1;
  localparam logic [LW-1:0] LOAD_TOP = LW'(WLOAD_CYCLES - 1);

  layer_state_e  state_q, state_d;
  logic [LW-1:0] load_cnt_q, load_cnt_d;
  logic          at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      load_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    in_ready   = 1'b0;
    wb_read    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (reload) begin
            state_d    = ST_LOAD;
            load_cnt_d = LOAD_TOP;
          end else begin
            state_d = ST_STREAM;
          end
        end
      end
      ST_LOAD: begin
        // Weight read is a single pulse at the top of the load window
        wb_read = (load_cnt_q == LOAD_TOP);
        if (load_cnt_q == '0) state_d = ST_STREAM;
        else                  load_cnt_d = load_cnt_q - 1'b1;
      end
      ST_STREAM: begin
        in_ready = 1'b1;
        if (in_valid && at_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign conv_en = in_valid & in_ready;

  window_counter #(
    .SIZE (SIZE),
    .K    (K)
  ) u_window_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q == ST_DONE),
    .acc       (conv_en),
    .at_last   (at_last),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_col   (out_col)
  );

`ifdef CONV3_CTRL_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_IDLE) && start)
      stall_cnt_d = '0;
    else if (in_ready && !in_valid && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
